// File: rtl/stack_sequencer.sv
// Expands one Forth stack word per handshake into SmartStack fetch/store/function pulses.
// Optional macro STACK_SEQ_ROT_EN enables the ROT word (opcode 9) and its third operand register.
module stack_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [3:0]                 i_opcode,
    input  logic [WIDTH-1:0]           i_imm,
    output logic                       o_ready,
    output logic                       o_done,
    output logic                       o_err,
    output logic [$clog2(DEPTH+1)-1:0] o_depth,
    output logic                       o_fetch,
    output logic                       o_store,
    output logic [2:0]                 o_function,
    output logic [WIDTH-1:0]           o_write_D,
    input  logic [WIDTH-1:0]           i_read_A,
    input  logic [WIDTH-1:0]           i_read_B
);
    localparam int DW = $clog2(DEPTH+1);

    localparam logic [3:0] OP_NOP  = 4'd0, OP_LIT  = 4'd1, OP_DUP = 4'd2, OP_DROP = 4'd3,
                           OP_SWAP = 4'd4, OP_OVER = 4'd5, OP_NIP = 4'd6, OP_ADD  = 4'd7,
                           OP_SUB  = 4'd8, OP_ROT  = 4'd9;
    localparam logic [2:0] F_PUSH = 3'b000, F_POP = 3'b001, F_POPR = 3'b011, F_NOP = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_STORE, S_DONE} state_t;

    state_t             state, state_n;
    logic [3:0]         op_q, op_sel;
    logic [1:0]         step, step_n, last_step;
    logic [WIDTH-1:0]   ra, rb, a_v, b_v;
    logic               inc_q, dec_q, inc_sel, dec_sel;
    logic               legal, net_inc, net_dec, reject, accept;
    logic [1:0]         min_d;
    logic               fetch_n, store_n, done_n, err_n;
    logic [2:0]         func_n;
    logic [WIDTH-1:0]   wd_n;
    logic [DW-1:0]      depth_n;
`ifdef STACK_SEQ_ROT_EN
    logic [WIDTH-1:0]   rc, c_v;
`endif

    assign o_ready = (state == S_IDLE);
    assign accept  = i_valid && o_ready;
    assign op_sel  = (state == S_IDLE) ? i_opcode : op_q;

    // Admission check is made on the incoming opcode against the current depth
    always_comb begin
        legal   = 1'b1;
        min_d   = 2'd0;
        net_inc = 1'b0;
        net_dec = 1'b0;
        case (i_opcode)
            OP_NOP:  ;
            OP_LIT:  net_inc = 1'b1;
            OP_DUP:  begin min_d = 2'd1; net_inc = 1'b1; end
            OP_DROP: begin min_d = 2'd1; net_dec = 1'b1; end
            OP_SWAP: min_d = 2'd2;
            OP_OVER: begin min_d = 2'd2; net_inc = 1'b1; end
            OP_NIP, OP_ADD, OP_SUB: begin min_d = 2'd2; net_dec = 1'b1; end
`ifdef STACK_SEQ_ROT_EN
            OP_ROT:  min_d = 2'd3;
`endif
            default: legal = 1'b0;
        endcase
    end

    assign reject  = !legal || (o_depth < DW'(min_d)) || (net_inc && (o_depth == DW'(DEPTH)));
    assign inc_sel = (state == S_IDLE) ? (net_inc && !reject) : inc_q;
    assign dec_sel = (state == S_IDLE) ? (net_dec && !reject) : dec_q;

    always_comb begin
        case (op_q)
            OP_SWAP: last_step = 2'd1;
            OP_ROT:  last_step = 2'd3;
            default: last_step = 2'd0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    if (reject || i_opcode == OP_NOP)                  state_n = S_DONE;
                    else if (i_opcode == OP_LIT || i_opcode == OP_DROP) state_n = S_STORE;
                    else                                                state_n = S_FETCH;
                end
            end
            S_FETCH: state_n = S_LATCH;
            S_LATCH: state_n = S_STORE;
            S_STORE: begin
                if (step == last_step)                     state_n = S_DONE;
                else if (op_q == OP_ROT && step == 2'd0)   state_n = S_FETCH;
                else                                       state_n = S_STORE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Step advances on every store so ROT's second fetch resumes at micro-step 1
    always_comb begin
        if (state == S_IDLE)       step_n = 2'd0;
        else if (state == S_STORE) step_n = step + 2'd1;
        else                       step_n = step;
    end

    // Operands as they will be held during the next cycle
    assign a_v = (state == S_LATCH && step == 2'd0) ? i_read_A : ra;
    assign b_v = (state == S_LATCH && step == 2'd0) ? i_read_B : rb;
`ifdef STACK_SEQ_ROT_EN
    assign c_v = (state == S_LATCH && step != 2'd0) ? i_read_B : rc;
`endif

    // Output logic: next values for the registered outputs
    always_comb begin
        fetch_n = (state_n == S_FETCH);
        store_n = (state_n == S_STORE);
        done_n  = (state_n == S_DONE);
        err_n   = accept && reject;
        func_n  = F_NOP;
        wd_n    = '0;
        depth_n = o_depth;
        if (state_n == S_DONE)
            depth_n = o_depth + DW'(inc_sel) - DW'(dec_sel);
        if (store_n) begin
            case (op_sel)
                OP_LIT:  begin func_n = F_PUSH; wd_n = i_imm; end
                OP_DUP:  begin func_n = F_PUSH; wd_n = a_v; end
                OP_DROP: func_n = F_POP;
                OP_SWAP: begin
                    if (step_n == 2'd0) begin func_n = F_POPR; wd_n = a_v; end
                    else                begin func_n = F_PUSH; wd_n = b_v; end
                end
                OP_OVER: begin func_n = F_PUSH; wd_n = b_v; end
                OP_NIP:  begin func_n = F_POPR; wd_n = a_v; end
                OP_ADD:  begin func_n = F_POPR; wd_n = b_v + a_v; end
                OP_SUB:  begin func_n = F_POPR; wd_n = b_v - a_v; end
`ifdef STACK_SEQ_ROT_EN
                OP_ROT: begin
                    case (step_n)
                        2'd0:    func_n = F_POP;
                        2'd1:    begin func_n = F_POPR; wd_n = b_v; end
                        2'd2:    begin func_n = F_PUSH; wd_n = a_v; end
                        default: begin func_n = F_PUSH; wd_n = c_v; end
                    endcase
                end
`endif
                default: ;
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            step       <= 2'd0;
            op_q       <= 4'd0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            ra         <= '0;
            rb         <= '0;
`ifdef STACK_SEQ_ROT_EN
            rc         <= '0;
`endif
            o_fetch    <= 1'b0;
            o_store    <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_function <= F_NOP;
            o_write_D  <= '0;
            o_depth    <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            if (accept) begin
                op_q  <= i_opcode;
                inc_q <= net_inc && !reject;
                dec_q <= net_dec && !reject;
            end
            if (state == S_LATCH) begin
                if (step == 2'd0) begin
                    ra <= i_read_A;
                    rb <= i_read_B;
                end
`ifdef STACK_SEQ_ROT_EN
                else begin
                    rc <= i_read_B;
                end
`endif
            end
            o_fetch    <= fetch_n;
            o_store    <= store_n;
            o_done     <= done_n;
            o_err      <= err_n;
            o_function <= func_n;
            o_write_D  <= wd_n;
            o_depth    <= depth_n;
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a small SmartStack memory model on the fetch/store port.
module tb_stack_sequencer;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [3:0]  i_opcode;
    logic [15:0] i_imm;
    logic        o_ready, o_done, o_err, o_fetch, o_store;
    logic [3:0]  o_depth;
    logic [2:0]  o_function;
    logic [15:0] o_write_D;
    logic [15:0] i_read_A, i_read_B;

    int checks = 0;
    int errors = 0;

    logic [15:0] stk [0:15];
    int          sp;

    stack_sequencer #(.WIDTH(16), .DEPTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_opcode(i_opcode), .i_imm(i_imm),
        .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_depth(o_depth),
        .o_fetch(o_fetch), .o_store(o_store), .o_function(o_function), .o_write_D(o_write_D),
        .i_read_A(i_read_A), .i_read_B(i_read_B)
    );

    always #5 i_clk = ~i_clk;

    // SmartStack model: reads appear the cycle after a fetch, stores apply at the edge
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sp       <= 0;
            i_read_A <= '0;
            i_read_B <= '0;
        end else begin
            if (o_fetch) begin
                i_read_A <= (sp >= 1) ? stk[sp-1] : 16'h0;
                i_read_B <= (sp >= 2) ? stk[sp-2] : 16'h0;
            end
            if (o_store) begin
                case (o_function)
                    3'b000: begin stk[sp] <= o_write_D; sp <= sp + 1; end
                    3'b001: sp <= sp - 1;
                    3'b010: if (sp >= 1) stk[sp-1] <= o_write_D;
                    3'b011: if (sp >= 2) begin stk[sp-2] <= o_write_D; sp <= sp - 1; end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present a word in c0; returns sampling in c1
    task automatic issue(input logic [3:0] op, input logic [15:0] imm);
        i_valid  = 1'b1;
        i_opcode = op;
        i_imm    = imm;
        tick();
        i_valid  = 1'b0;
    endtask

    task automatic lit(input logic [15:0] v, input logic [3:0] d);
        issue(4'd1, v);
        chk("lit_store", o_store, 1);
        chk("lit_func", o_function, 3'b000);
        chk("lit_data", o_write_D, v);
        chk("lit_nofetch", o_fetch, 0);
        tick();
        chk("lit_done", o_done, 1);
        chk("lit_err", o_err, 0);
        chk("lit_depth", o_depth, d);
        tick();
    endtask

    task automatic rej(input string tag, input logic [3:0] op, input logic [3:0] d);
        issue(op, 16'h0);
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_err"}, o_err, 1);
        chk({tag, "_fetch"}, o_fetch, 0);
        chk({tag, "_store"}, o_store, 0);
        chk({tag, "_depth"}, o_depth, d);
        tick();
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_fetch2"}, o_fetch, 0);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_opcode = 4'd0; i_imm = 16'h0;
        tick(); tick();
        chk("rst_ready", o_ready, 1);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_fetch", o_fetch, 0);
        chk("rst_store", o_store, 0);
        chk("rst_func", o_function, 3'b111);
        chk("rst_wd", o_write_D, 0);
        chk("rst_depth", o_depth, 0);
        i_rst = 1'b0;

        // LIT, LIT, ADD
        lit(16'h00F0, 4'd1);
        lit(16'h0003, 4'd2);
        issue(4'd7, 16'h0);
        chk("add_fetch", o_fetch, 1);
        tick();
        chk("add_latch_nofetch", o_fetch, 0);
        chk("add_latch_nostore", o_store, 0);
        tick();
        chk("add_store", o_store, 1);
        chk("add_func", o_function, 3'b011);
        chk("add_data", o_write_D, 16'h00F3);
        tick();
        chk("add_done", o_done, 1);
        chk("add_depth", o_depth, 1);
        tick();
        chk("add_model_top", stk[sp-1], 16'h00F3);
        chk("add_model_sp", sp, 1);

        // DROP, then DROP on empty
        issue(4'd3, 16'h0);
        chk("drop_store", o_store, 1);
        chk("drop_func", o_function, 3'b001);
        tick();
        chk("drop_depth", o_depth, 0);
        tick();
        rej("drop_empty", 4'd3, 4'd0);

        // SWAP at depth 1
        lit(16'h0005, 4'd1);
        rej("swap_d1", 4'd4, 4'd1);

        // SUB with A=1, B=0
        lit(16'h0000, 4'd2);
        lit(16'h0001, 4'd3);
        issue(4'd8, 16'h0);
        tick(); tick();
        chk("sub_store", o_store, 1);
        chk("sub_func", o_function, 3'b011);
        chk("sub_data", o_write_D, 16'hFFFF);
        tick();
        chk("sub_done", o_done, 1);
        chk("sub_depth", o_depth, 2);
        tick();

        rej("illegal12", 4'd12, 4'd2);

        // OVER with i_valid held while busy: exactly one word
        i_valid = 1'b1; i_opcode = 4'd5; i_imm = 16'h0;
        tick();
        chk("over_fetch", o_fetch, 1);
        tick();
        chk("over_busy", o_ready, 0);
        tick();
        chk("over_store", o_store, 1);
        chk("over_func", o_function, 3'b000);
        chk("over_data", o_write_D, 16'h0005);
        tick();
        chk("over_done", o_done, 1);
        chk("over_depth", o_depth, 3);
        i_valid = 1'b0;
        tick();
        chk("over_ready", o_ready, 1);
        chk("over_no_refetch", o_fetch, 0);
        chk("over_no_redone", o_done, 0);
        chk("over_depth_hold", o_depth, 3);

        // ROT on ... 1 2 3
        lit(16'h0001, 4'd4);
        lit(16'h0002, 4'd5);
        lit(16'h0003, 4'd6);
`ifdef STACK_SEQ_ROT_EN
        issue(4'd9, 16'h0);
        chk("rot_fetch1", o_fetch, 1);
        tick(); tick();
        chk("rot_pop", o_store, 1);
        chk("rot_pop_func", o_function, 3'b001);
        tick();
        chk("rot_fetch2", o_fetch, 1);
        tick(); tick();
        chk("rot_s6_func", o_function, 3'b011);
        chk("rot_s6_data", o_write_D, 16'h0002);
        tick();
        chk("rot_s7_func", o_function, 3'b000);
        chk("rot_s7_data", o_write_D, 16'h0003);
        tick();
        chk("rot_s8_func", o_function, 3'b000);
        chk("rot_s8_data", o_write_D, 16'h0001);
        tick();
        chk("rot_done", o_done, 1);
        chk("rot_err", o_err, 0);
        chk("rot_depth", o_depth, 6);
        tick();
        chk("rot_model_top", stk[sp-1], 16'h0001);
        chk("rot_model_2nd", stk[sp-2], 16'h0003);
        chk("rot_model_3rd", stk[sp-3], 16'h0002);
`else
        rej("rot_disabled", 4'd9, 4'd6);
`endif

        // Fill to DEPTH, then overflow attempts
        lit(16'h0007, 4'd7);
        lit(16'h0008, 4'd8);
        rej("lit_full", 4'd1, 4'd8);
        rej("dup_full", 4'd2, 4'd8);

        // Reset in the middle of SWAP
        issue(4'd4, 16'h0);
        chk("swap_fetch", o_fetch, 1);
        tick(); tick();
        chk("swap_store", o_store, 1);
        chk("swap_data", o_write_D, 16'h0008);
        i_rst = 1'b1;
        #1;
        chk("midrst_store", o_store, 0);
        chk("midrst_func", o_function, 3'b111);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_depth", o_depth, 0);
        i_rst = 1'b0;
        tick();
        chk("postrst_nostore", o_store, 0);
        lit(16'h0009, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
